// File: rtl/sudoku_pkg.sv
// sudoku_pkg: shared grid constants, cell geometry helpers and loader states
package sudoku_pkg;
  localparam int CELLS = 81;
  localparam int DIGIT_W = 4;
  localparam int GRID_W = CELLS * DIGIT_W;
  localparam int N = 9;
  typedef enum logic {S_LOAD, S_DONE} load_state_t;
  function automatic logic [3:0] cell_row(input logic [6:0] i);
    return 4'(i / 7'(N));
  endfunction
  function automatic logic [3:0] cell_col(input logic [6:0] i);
    return 4'(i % 7'(N));
  endfunction
  function automatic logic [6:0] box_base(input logic [6:0] i);
    logic [6:0] r, c;
    r = i / 7'(N);
    c = i % 7'(N);
    return 7'd27 * (r / 7'd3) + 7'd3 * (c / 7'd3);
  endfunction
endpackage

// File: rtl/sudoku_conflict_check.sv
// sudoku_conflict_check: flags din already present among written row/column/box peers of idx
module sudoku_conflict_check
  import sudoku_pkg::*;
(
  input  logic [GRID_W-1:0]  grid,
  input  logic [6:0]         idx,
  input  logic [DIGIT_W-1:0] din,
  output logic               conflict
);
  // Cells at or beyond idx are unwritten, so only lower indices are peers.
  always_comb begin
    conflict = 1'b0;
    for (int j = 0; j < CELLS; j++) begin
      conflict = conflict | ((7'(j) < idx) && (din != '0) && (grid[DIGIT_W*j +: DIGIT_W] == din) &&
                 (cell_row(7'(j)) == cell_row(idx) || cell_col(7'(j)) == cell_col(idx) ||
                  box_base(7'(j)) == box_base(idx)));
    end
  end
endmodule

// File: rtl/sudoku_grid_loader.sv
// sudoku_grid_loader: press-driven cell-by-cell puzzle entry building the packed solver grid
module sudoku_grid_loader
  import sudoku_pkg::*;
#(
  parameter bit CHECK_CONFLICT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                next,
  input  logic [DIGIT_W-1:0]  din,
  output logic [3:0]          row_d,
  output logic [3:0]          col_d,
  output logic [DIGIT_W-1:0]  val_d,
  output logic                err,
  output logic                done,
  output logic [GRID_W-1:0]   grid
);
  load_state_t state, state_n;
  logic next_q, press, last, conflict, accept, reject;
  logic [6:0] idx;
  sudoku_conflict_check u_check (
    .grid     (grid),
    .idx      (idx),
    .din      (din),
    .conflict (conflict)
  );
  always_comb begin
    press = next & ~next_q;
    last = idx == 7'(CELLS - 1);
    accept = (state == S_LOAD) && press && (din <= 4'd9) && (din == '0 || !CHECK_CONFLICT || !conflict);
    reject = (state == S_LOAD) && press && !accept;
    state_n = (accept && last) ? S_DONE : state;
  end
  // next_q resets high so a push held across reset release is not taken as a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOAD;
      next_q <= 1'b1;
      idx <= '0;
      row_d <= 4'd1;
      col_d <= 4'd1;
      val_d <= '0;
      err <= 1'b0;
      done <= 1'b0;
      grid <= '0;
    end else begin
      state <= state_n;
      next_q <= next;
      err <= reject;
      done <= state_n == S_DONE;
      if (accept) begin
        grid[DIGIT_W*idx +: DIGIT_W] <= din;
        val_d <= din;
        if (!last) begin
          idx <= idx + 7'd1;
          col_d <= (col_d == 4'd9) ? 4'd1 : col_d + 4'd1;
          row_d <= (col_d == 4'd9) ? row_d + 4'd1 : row_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_sudoku_grid_loader.sv
// tb_sudoku_grid_loader: directed checks of entry, rejection, press edge, reset and full-grid packing
module tb_sudoku_grid_loader;
  import sudoku_pkg::*;
  logic clk, reset, next;
  logic [3:0] din;
  logic [3:0] a_row, a_col, a_val, b_row, b_col, b_val;
  logic a_err, a_done, b_err, b_done;
  logic [GRID_W-1:0] a_grid, b_grid, exp_grid;
  int total, bad;
  logic e_hit, e_tail, e_acc, b_hit, b_acc;
  logic [35:0] rows [9];

  sudoku_grid_loader #(.CHECK_CONFLICT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .next(next), .din(din),
    .row_d(a_row), .col_d(a_col), .val_d(a_val), .err(a_err), .done(a_done), .grid(a_grid)
  );
  sudoku_grid_loader #(.CHECK_CONFLICT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .next(next), .din(din),
    .row_d(b_row), .col_d(b_col), .val_d(b_val), .err(b_err), .done(b_done), .grid(b_grid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [GRID_W-1:0] obs, input logic [GRID_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    next = 1'b0;
    din = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    e_acc = 1'b0;
    b_acc = 1'b0;
  endtask

  task automatic push(input logic [3:0] d);
    din = d;
    next = 1'b1;
    @(posedge clk); #1;
    e_hit = a_err;
    b_hit = b_err;
    next = 1'b0;
    @(posedge clk); #1;
    e_tail = a_err;
    e_acc = e_acc | e_hit | e_tail;
    b_acc = b_acc | b_hit | b_err;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rows[0] = 36'h123456789; rows[1] = 36'h456789123; rows[2] = 36'h789123456;
    rows[3] = 36'h234567891; rows[4] = 36'h567891234; rows[5] = 36'h891234567;
    rows[6] = 36'h345678912; rows[7] = 36'h678912345; rows[8] = 36'h912345678;
    exp_grid = '0;
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 9; c++)
        exp_grid[4*(9*r+c) +: 4] = rows[r][4*(8-c) +: 4];
    next = 1'b0;
    din = '0;
    reset = 1'b1;
    #3;
    chk("rst_grid", a_grid, '0);
    chk("rst_row", 324'(a_row), 324'd1);
    chk("rst_col", 324'(a_col), 324'd1);
    chk("rst_val", 324'(a_val), 324'd0);
    chk("rst_err", 324'(a_err), 324'd0);
    chk("rst_done", 324'(a_done), 324'd0);

    // 1: 81 blanks
    do_reset();
    for (int k = 0; k < 80; k++) push(4'd0);
    chk("t1_row80", 324'(a_row), 324'd9);
    chk("t1_col80", 324'(a_col), 324'd9);
    chk("t1_done_early", 324'(a_done), 324'd0);
    push(4'd0);
    chk("t1_done", 324'(a_done), 324'd1);
    chk("t1_row", 324'(a_row), 324'd9);
    chk("t1_col", 324'(a_col), 324'd9);
    chk("t1_grid", a_grid, '0);
    chk("t1_noerr", 324'(e_acc), 324'd0);
    push(4'd5);
    chk("t1_ignored_err", 324'(e_hit), 324'd0);
    chk("t1_ignored_grid", a_grid, '0);
    chk("t1_ignored_val", 324'(a_val), 324'd0);

    // 2: row conflict then recovery; CHECK_CONFLICT=0 instance accepts duplicates
    do_reset();
    push(4'd5);
    chk("t2_col1", 324'(a_col), 324'd2);
    chk("t2_val1", 324'(a_val), 324'd5);
    push(4'd5);
    chk("t2_err", 324'(e_hit), 324'd1);
    chk("t2_err_1cyc", 324'(e_tail), 324'd0);
    chk("t2_col_hold", 324'(a_col), 324'd2);
    chk("t2_cell1", 324'(a_grid[7:4]), 324'd0);
    chk("t2_b_col", 324'(b_col), 324'd3);
    chk("t2_b_grid", 324'(b_grid[7:0]), 324'h55);
    chk("t2_b_noerr", 324'(b_acc), 324'd0);
    push(4'd3);
    chk("t2_cells", 324'(a_grid[7:0]), 324'h35);
    chk("t2_col3", 324'(a_col), 324'd3);
    chk("t2_val3", 324'(a_val), 324'd3);

    // 3: out-of-range digit, then row-only conflict
    do_reset();
    push(4'd12);
    chk("t3_err", 324'(e_hit), 324'd1);
    chk("t3_b_err", 324'(b_hit), 324'd1);
    chk("t3_col", 324'(a_col), 324'd1);
    chk("t3_val", 324'(a_val), 324'd0);
    push(4'd7);
    chk("t3_cell0", 324'(a_grid[3:0]), 324'd7);
    chk("t3_col2", 324'(a_col), 324'd2);
    for (int k = 0; k < 3; k++) push(4'd0);
    push(4'd7);
    chk("t3_rowconf", 324'(e_hit), 324'd1);
    chk("t3_rowconf_col", 324'(a_col), 324'd5);

    // 4: box conflict, column-distinct box accept, column-only conflict
    do_reset();
    push(4'd4);
    for (int k = 0; k < 9; k++) push(4'd0);
    push(4'd4);
    chk("t4_boxconf", 324'(e_hit), 324'd1);
    chk("t4_box_row", 324'(a_row), 324'd2);
    chk("t4_box_col", 324'(a_col), 324'd2);
    push(4'd0);
    for (int k = 0; k < 17; k++) push(4'd0);
    e_acc = 1'b0;
    push(4'd4);
    chk("t4_accept_err", 324'(e_acc), 324'd0);
    chk("t4_cell28", 324'(a_grid[4*28 +: 4]), 324'd4);
    chk("t4_row", 324'(a_row), 324'd4);
    chk("t4_col", 324'(a_col), 324'd3);
    for (int k = 0; k < 26; k++) push(4'd0);
    push(4'd4);
    chk("t4_colconf", 324'(e_hit), 324'd1);
    chk("t4_colconf_row", 324'(a_row), 324'd7);

    // 5: held push gives one entry; push held through reset is not a press
    do_reset();
    din = 4'd6;
    next = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_hold_col", 324'(a_col), 324'd2);
    chk("t5_hold_grid", a_grid, 324'h6);
    next = 1'b0;
    @(posedge clk); #1;
    next = 1'b1;
    din = 4'd2;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_rst_hold_col", 324'(a_col), 324'd1);
    chk("t5_rst_hold_grid", a_grid, '0);
    next = 1'b0;
    @(posedge clk); #1;
    push(4'd2);
    chk("t5_repress_col", 324'(a_col), 324'd2);
    chk("t5_repress_grid", a_grid, 324'h2);

    // 6: async reset mid-load, then full valid grid
    do_reset();
    for (int i = 0; i < 40; i++) push(rows[i/9][4*(8-i%9) +: 4]);
    chk("t6_part_row", 324'(a_row), 324'd5);
    chk("t6_part_col", 324'(a_col), 324'd5);
    chk("t6_part_grid", a_grid, exp_grid & ((324'd1 << 160) - 324'd1));
    reset = 1'b1;
    #2;
    chk("t6_async_grid", a_grid, '0);
    chk("t6_async_row", 324'(a_row), 324'd1);
    chk("t6_async_col", 324'(a_col), 324'd1);
    chk("t6_async_done", 324'(a_done), 324'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    e_acc = 1'b0;
    for (int i = 0; i < 81; i++) push(rows[i/9][4*(8-i%9) +: 4]);
    chk("t6_full_grid", a_grid, exp_grid);
    chk("t6_full_done", 324'(a_done), 324'd1);
    chk("t6_full_noerr", 324'(e_acc), 324'd0);
    chk("t6_full_val", 324'(a_val), 324'd8);
    chk("t6_b_grid", b_grid, exp_grid);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
